// File: rtl/int_dump_pkg.sv
// Shared sizing helpers and parameter legality checks for the int_dump decimator.
package int_dump_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // Accumulator width: wide enough that ratio full-scale samples never wrap.
    function automatic int full_w(input int lw, input int r);
        return lw + clog2(r);
    endfunction

    function automatic int drop_w(input int lw, input int r, input int ow);
        return full_w(lw, r) - ow;
    endfunction

    function automatic int phase_w(input int r);
        return (clog2(r) < 1) ? 1 : clog2(r);
    endfunction

    function automatic bit params_ok(input int lw, input int r, input int ow);
        return (lw >= 1) && (r >= 1) && (ow >= 1) && (ow <= full_w(lw, r));
    endfunction

endpackage

// File: rtl/int_dump_scale.sv
// Combinational FULL_W -> OUT_W scaling: floor shift by default, round-half-up
// with positive saturation when INT_DUMP_ROUND_EN is defined.
module int_dump_scale #(
    parameter int FULL_W = 10,
    parameter int OUT_W  = 10,
    parameter int D      = 0
) (
    input  logic signed [FULL_W-1:0] sum,
    output logic signed [OUT_W-1:0]  q
);

    if (D == 0) begin : g_ident
        assign q = sum;
    end else begin : g_shift
`ifdef INT_DUMP_ROUND_EN
        localparam logic [FULL_W:0] HALF = (FULL_W + 1)'(1) << (D - 1);
        logic [FULL_W:0] rnd;
        logic [D-1:0]    unused_rnd_lsb;
        logic            sat;

        // One extra bit holds the carry of the rounding add; only the positive side can overflow.
        assign rnd            = {sum[FULL_W-1], sum} + HALF;
        assign unused_rnd_lsb = rnd[D-1:0];
        assign sat            = ~rnd[FULL_W] & rnd[FULL_W-1];
        assign q              = sat ? {1'b0, {(OUT_W - 1){1'b1}}} : rnd[FULL_W-1:D];
`else
        logic [D-1:0] unused_sum_lsb;

        assign unused_sum_lsb = sum[D-1:0];
        assign q              = sum[FULL_W-1:D];
`endif
    end

endmodule

// File: rtl/int_dump.sv
// Integrate-and-dump decimator: sums ratio valid samples and emits one scaled sum.
// Rounding/saturation is selected with the INT_DUMP_ROUND_EN macro.
module int_dump
    import int_dump_pkg::*;
#(
    parameter int lpm_width = 8,
    parameter int ratio     = 4,
    parameter int out_width = 10
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              clear,
    input  logic                              in_valid,
    input  logic signed [lpm_width-1:0]       data,
    output logic signed [out_width-1:0]       q,
    output logic                              q_valid,
    output logic [phase_w(ratio)-1:0]         phase
);

    localparam int FULL_W = full_w(lpm_width, ratio);
    localparam int D      = drop_w(lpm_width, ratio, out_width);
    localparam int PH_W   = phase_w(ratio);

    if (!params_ok(lpm_width, ratio, out_width)) begin : g_bad_params
        $error("int_dump: need ratio >= 1 and out_width <= lpm_width + clog2(ratio)");
    end

    logic signed [FULL_W-1:0] acc;
    logic signed [FULL_W-1:0] sum;
    logic signed [out_width-1:0] scaled;
    logic [PH_W-1:0]          count;
    logic                     last;

    assign sum   = acc + FULL_W'(data);
    assign last  = (count == PH_W'(ratio - 1));
    assign phase = count;

    int_dump_scale #(
        .FULL_W (FULL_W),
        .OUT_W  (out_width),
        .D      (D)
    ) u_scale (
        .sum (sum),
        .q   (scaled)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            count   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            count   <= '0;
            q_valid <= 1'b0;
        end else if (in_valid) begin
            // The dump cycle restarts the block directly so the next sample is index 0.
            if (last) begin
                q       <= scaled;
                q_valid <= 1'b1;
                acc     <= '0;
                count   <= '0;
            end else begin
                acc     <= sum;
                count   <= count + PH_W'(1);
                q_valid <= 1'b0;
            end
        end else begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int_dump.sv
// Scoreboard bench for int_dump: three configurations (default, out_width=8, ratio=1).
module tb_int_dump;

    typedef struct packed {
        int q;
        int cyc;
    } exp_t;

`ifdef INT_DUMP_ROUND_EN
    localparam int B_SUM10 = 3;
    localparam int B_SUMN6 = -1;
`else
    localparam int B_SUM10 = 2;
    localparam int B_SUMN6 = -2;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    always @(posedge clock) cyc <= cyc + 1;

    logic              a_clr, a_vld, a_qv;
    logic signed [7:0] a_data;
    logic signed [9:0] a_q;
    logic [1:0]        a_ph;
    logic              b_clr, b_vld, b_qv;
    logic signed [7:0] b_data, b_q;
    logic [1:0]        b_ph;
    logic              c_clr, c_vld, c_qv;
    logic signed [7:0] c_data, c_q;
    logic [0:0]        c_ph;

    int_dump u_a (
        .clock(clock), .reset_n(reset_n), .clear(a_clr), .in_valid(a_vld),
        .data(a_data), .q(a_q), .q_valid(a_qv), .phase(a_ph)
    );
    int_dump #(.out_width(8)) u_b (
        .clock(clock), .reset_n(reset_n), .clear(b_clr), .in_valid(b_vld),
        .data(b_data), .q(b_q), .q_valid(b_qv), .phase(b_ph)
    );
    int_dump #(.ratio(1), .out_width(8)) u_c (
        .clock(clock), .reset_n(reset_n), .clear(c_clr), .in_valid(c_vld),
        .data(c_data), .q(c_q), .q_valid(c_qv), .phase(c_ph)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Monitors: every strobe must match the head of its queue in value and cycle.
    always @(negedge clock) if (reset_n && a_qv) begin
        exp_t e;
        if (qa.size() == 0) begin
            checks++;
            $display("FAIL a_strobe: unexpected q=%0d at cycle %0d, expected none", a_q, cyc);
        end else begin
            e = qa.pop_front();
            chk("a_q", int'(a_q), e.q);
            chk("a_latency", cyc, e.cyc);
        end
    end

    always @(negedge clock) if (reset_n && b_qv) begin
        exp_t e;
        if (qb.size() == 0) begin
            checks++;
            $display("FAIL b_strobe: unexpected q=%0d at cycle %0d, expected none", b_q, cyc);
        end else begin
            e = qb.pop_front();
            chk("b_q", int'(b_q), e.q);
            chk("b_latency", cyc, e.cyc);
        end
    end

    always @(negedge clock) if (reset_n && c_qv) begin
        exp_t e;
        if (qc.size() == 0) begin
            checks++;
            $display("FAIL c_strobe: unexpected q=%0d at cycle %0d, expected none", c_q, cyc);
        end else begin
            e = qc.pop_front();
            chk("c_q", int'(c_q), e.q);
            chk("c_latency", cyc, e.cyc);
        end
    end

    task automatic a_smp(input int v);
        @(negedge clock);
        a_vld = 1'b1; a_data = 8'(v);
    endtask
    task automatic a_idle(input int n);
        repeat (n) begin @(negedge clock); a_vld = 1'b0; end
    endtask
    task automatic b_smp(input int v);
        @(negedge clock);
        b_vld = 1'b1; b_data = 8'(v);
    endtask
    task automatic c_smp(input int v);
        @(negedge clock);
        c_vld = 1'b1; c_data = 8'(v);
    endtask

    // A strobe is due one edge after the edge that samples the currently driven sample.
    function automatic exp_t due(input int v);
        exp_t e;
        e.q = v;
        e.cyc = cyc + 1;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        a_clr = 0; a_vld = 0; a_data = 0;
        b_clr = 0; b_vld = 0; b_data = 0;
        c_clr = 0; c_vld = 0; c_data = 0;
        #3;
        chk("rst_a_q", int'(a_q), 0);
        chk("rst_a_qv", int'(a_qv), 0);
        chk("rst_a_phase", int'(a_ph), 0);
        chk("rst_b_q", int'(b_q), 0);
        chk("rst_c_q", int'(c_q), 0);
        chk("rst_c_qv", int'(c_qv), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1,2,3,4 -> 10 with phase 0,1,2,3,0
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t1_phase", int'(a_ph), i);
            a_vld = 1'b1; a_data = 8'(i + 1);
        end
        qa.push_back(due(10));
        @(negedge clock);
        a_vld = 1'b0;
        chk("t1_phase_wrap", int'(a_ph), 0);

        // extremes, back to back blocks
        repeat (4) a_smp(-128);
        qa.push_back(due(-512));
        repeat (4) a_smp(127);
        qa.push_back(due(508));
        a_idle(1);

        // gaps stretch a block
        a_smp(5); a_idle(3); a_smp(5); a_idle(1); a_smp(5); a_smp(5);
        qa.push_back(due(20));
        a_idle(2);

        // clear with a coincident sample that would otherwise dump
        repeat (3) a_smp(3);
        @(negedge clock);
        a_clr = 1'b1; a_vld = 1'b1; a_data = 8'd100;
        @(negedge clock);
        a_clr = 1'b0; a_vld = 1'b0;
        chk("clr_phase", int'(a_ph), 0);
        repeat (4) a_smp(1);
        qa.push_back(due(4));
        a_idle(2);

        // asynchronous reset mid-block
        a_smp(7); a_smp(7);
        @(negedge clock);
        a_vld = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_a_q", int'(a_q), 0);
        chk("arst_a_qv", int'(a_qv), 0);
        chk("arst_a_phase", int'(a_ph), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) a_smp(2);
        qa.push_back(due(8));
        a_idle(2);

        // out_width=8, two LSBs dropped
        b_smp(1); b_smp(2); b_smp(3); b_smp(4);
        qb.push_back(due(B_SUM10));
        b_smp(-1); b_smp(-2); b_smp(-3); b_smp(0);
        qb.push_back(due(B_SUMN6));
        @(negedge clock); b_vld = 1'b0;

        // ratio=1 pass-through, strobe on consecutive cycles
        c_smp(7);
        qc.push_back(due(7));
        c_smp(-3);
        qc.push_back(due(-3));
        @(negedge clock); c_vld = 1'b0;

        repeat (4) @(negedge clock);
        chk("a_drain", qa.size(), 0);
        chk("b_drain", qb.size(), 0);
        chk("c_drain", qc.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
